// File: rtl/bit_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder_pkg
// Purpose  : Shared state encoding and default width for the bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package bit_serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_serial_adder_fa_cell.sv
`default_nettype none
// ============================================================================
// Module   : serial_fa_cell
// Purpose  : Single full-adder cell with the B input gated by en.
// Revision : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic en,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic b_eff;

  assign b_eff = b & en;
  assign s     = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

endmodule
`default_nettype wire

// File: rtl/bit_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_adder
// Purpose  : LSB-first serial adder (sum = A + (B & en)) with parallel result.
// Revision : 1.0 - initial release
// ============================================================================
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic             bit_valid,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int             CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_s;
  logic             fa_cout;
  logic             last_bit;

  serial_fa_cell u_fa (
    .a    (a_bit),
    .b    (b_bit),
    .en   (en),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = bit_valid && (cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clr) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) next_state = SHIFT;
        SHIFT:   if (last_bit) next_state = DONE;
        DONE:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Datapath; carry_out only updates on the final bit so it holds between runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else if (clr) begin
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            carry <= fa_cout;
            sum   <= {fa_s, sum[WIDTH-1:1]};
            cnt   <= cnt + CNT_W'(1);
            if (last_bit) carry_out <= fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
`default_nettype wire
